adder8_seq_ctrl: RTL

//   Multi-precision add sequencer: adds two NBYTES*8-bit operands LSB-byte first through one

---
 rtl/adder8_seq_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/adder8_seq_ctrl.sv
// Multi-precision add sequencer: one adder8 walks NBYTES bytes LSB-first, chaining carry in a register; optional subtract via ADD_SEQ_SUB_EN.
// Latency: accept edge, then NBYTES RUN cycles, then a one-cycle DONE; one op per NBYTES+2 cycles.
// Backpressure: ready is high only in IDLE; start outside IDLE is ignored, not queued.

module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] w_full;

    // Plain 8-bit ripple add with carry in/out
    assign w_full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    assign sum    = w_full[7:0];
    assign cout   = w_full[8];
endmodule

module adder8_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                cout
);
    localparam int WIDTH = 8 * NBYTES;
    localparam int IDXW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic [WIDTH-1:0] w_op_b_in;
    logic             w_cin_in;
    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;
    logic [7:0]       w_sum;
    logic             w_cout;
    logic             w_accept;

    // Subtract is A + ~B + 1, so it only alters what is latched at accept
`ifdef ADD_SEQ_SUB_EN
    assign w_op_b_in = sub ? ~op_b : op_b;
    assign w_cin_in  = sub ? 1'b1 : cin;
`else
    assign w_op_b_in = op_b;
    assign w_cin_in  = cin;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_a_byte = r_op_a[8*r_idx +: 8];
    assign w_b_byte = r_op_b[8*r_idx +: 8];

    adder8 u_adder8 (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Sequencer: latch operands on accept, fold one byte per RUN cycle, pulse DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a  <= op_a;
                        r_op_b  <= w_op_b_in;
                        r_carry <= w_cin_in;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[8*r_idx +: 8] <= w_sum;
                    r_carry                <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_cout;
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign cout   = r_cout;
endmodule
